// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the counter-width helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the bit counter for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/result handshake bundle of the bit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;

  modport master (
    output start_valid, op_sub, a, b, result_ready,
    input  start_ready, result_valid, result, cout, busy
  );

  modport slave (
    input  start_valid, op_sub, a, b, result_ready,
    output start_ready, result_valid, result, cout, busy
  );
endinterface

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock LSB first, valid/ready on both ends.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_addsub_if.slave  bus
);
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] sh_a, sh_b, acc;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             rv;
  logic             fa_sum, fa_cout;
  logic             last;

  fa_cell u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last = (count == CNT_W'(WIDTH - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start_valid) next_state = SHIFT;
      SHIFT:   if (last) next_state = DONE;
      DONE:    if (bus.result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      rv    <= 1'b0;
    end else begin
      rv <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            sh_a  <= bus.a;
            sh_b  <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub;
            count <= '0;
          end
        end
        SHIFT: begin
          acc   <= {fa_sum, acc[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= fa_cout;
          count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // acc and carry only move in SHIFT, so they hold steady through DONE.
  assign bus.result       = acc;
  assign bus.cout         = carry;
  assign bus.result_valid = rv;
  assign bus.start_ready  = (state == IDLE);
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: vector table at WIDTH=8, hand sequences for
// back-pressure/intrusion/reset, and an exhaustive WIDTH=4 sweep.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if8 ();
  serial_addsub_if #(.WIDTH(4)) if4 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic       ec;
    int         hold;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_op8(input logic op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic ec, input int hold,
                        input bit intrude, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_ready"}, 32'(if8.start_ready), 32'd1);
    if8.start_valid = 1'b1;
    if8.op_sub      = op;
    if8.a           = x;
    if8.b           = y;
    @(posedge clk); #1;
    if8.start_valid = 1'b0;
    if8.a           = ~x;
    if8.b           = x ^ y;
    if8.op_sub      = ~op;
    n = 0;
    while (!if8.result_valid && n < 20) begin
      if (intrude && n == 3) begin
        check({tag, "_busy_ready"}, {30'd0, if8.busy, if8.start_ready}, 32'd2);
        if8.start_valid = 1'b1;
        if8.a           = 8'hFF;
        if8.b           = 8'h0F;
      end
      if (intrude && n == 4) if8.start_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_result"}, {23'd0, if8.cout, if8.result}, {23'd0, ec, er});
    for (int j = 0; j < hold; j++) begin
      if (intrude && j == 0) begin
        if8.start_valid = 1'b1;
        if8.op_sub      = 1'b1;
        if8.a           = 8'h01;
        if8.b           = 8'hAA;
      end
      @(posedge clk); #1;
      check({tag, "_hold"}, {22'd0, if8.result_valid, if8.cout, if8.result}, {22'd0, 1'b1, ec, er});
    end
    if8.start_valid  = 1'b0;
    if8.result_ready = 1'b1;
    @(posedge clk); #1;
    if8.result_ready = 1'b0;
    check({tag, "_release"}, {30'd0, if8.result_valid, if8.start_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    logic [3:0] xa, ya, er4;
    logic [4:0] s5;
    logic       ec4;

    vecs[0] = '{1'b0, 8'h3C, 8'h25, 8'h61, 1'b0, 0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 0};
    vecs[2] = '{1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 0};
    vecs[3] = '{1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 0};
    vecs[4] = '{1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 0};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 2};
    vecs[6] = '{1'b1, 8'h00, 8'hFF, 8'h01, 1'b0, 0};
    vecs[7] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 0};
    vecs[8] = '{1'b1, 8'hC8, 8'h64, 8'h64, 1'b1, 0};

    rst_n = 1'b0;
    if8.start_valid = 1'b0; if8.op_sub = 1'b0; if8.a = '0; if8.b = '0; if8.result_ready = 1'b0;
    if4.start_valid = 1'b0; if4.op_sub = 1'b0; if4.a = '0; if4.b = '0; if4.result_ready = 1'b0;
    #22;
    check("reset_outputs",
          {19'd0, if8.result, if8.cout, if8.result_valid, if8.busy, if8.start_ready},
          32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_op8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].ec, vecs[i].hold, 1'b0,
             $sformatf("vec%0d", i));

    // back-pressure for 5 cycles plus start_valid intrusion in SHIFT and DONE
    do_op8(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 5, 1'b1, "intrude");

    // reset 3 edges into the operation
    @(negedge clk);
    if8.start_valid = 1'b1; if8.op_sub = 1'b0; if8.a = 8'h77; if8.b = 8'h11;
    @(posedge clk); #1;
    if8.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs",
          {19'd0, if8.result, if8.cout, if8.result_valid, if8.busy, if8.start_ready},
          32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    if8.result_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (if8.result_valid || !if8.start_ready) seen++;
    end
    if8.result_ready = 1'b0;
    check("abort_no_valid", 32'(seen), 32'd0);
    do_op8(1'b0, 8'h02, 8'h03, 8'h05, 1'b0, 0, 1'b0, "post_rst");

    // WIDTH=4 exhaustive, back-to-back with result_ready held high
    if4.result_ready = 1'b1;
    @(negedge clk);
    for (int op = 0; op < 2; op++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          xa = 4'(x);
          ya = 4'(y);
          if (op == 0) begin
            s5  = {1'b0, xa} + {1'b0, ya};
            er4 = s5[3:0];
            ec4 = s5[4];
          end else begin
            er4 = 4'(x - y);
            ec4 = (x >= y);
          end
          n = 0;
          while (!if4.start_ready && n < 10) begin
            @(negedge clk);
            n++;
          end
          if4.start_valid = 1'b1;
          if4.op_sub      = op[0];
          if4.a           = xa;
          if4.b           = ya;
          @(posedge clk); #1;
          if4.start_valid = 1'b0;
          if4.a           = ~xa;
          n = 0;
          while (!if4.result_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
          end
          check($sformatf("w4_op%0d_%0d_%0d_latency", op, x, y), 32'(n), 32'd4);
          check($sformatf("w4_op%0d_%0d_%0d_result", op, x, y),
                {27'd0, if4.cout, if4.result}, {27'd0, ec4, er4});
          @(negedge clk);
        end
      end
    end
    if4.result_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
